// File: rtl/modexp_pkg.sv
// Shared types and constants for the modular-exponentiation controller.
package modexp_pkg;

  localparam int DEFAULT_W = 16;

  localparam logic [1:0] SLOT_C = 2'd0;
  localparam logic [1:0] SLOT_D = 2'd1;
  localparam logic [1:0] SLOT_N = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_MUL,
    ST_SQR,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/modexp_ctrl_operand_bank.sv
// Operand storage for C, D and N: round-robin load slot plus a mux that
// selects the most recently written slot for display.
module operand_bank
  import modexp_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] sw,
  output logic [W-1:0] op_c,
  output logic [W-1:0] op_d,
  output logic [W-1:0] op_n,
  output logic [W-1:0] last,
  output logic [1:0]   load_idx
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_c     <= '0;
      op_d     <= '0;
      op_n     <= '0;
      load_idx <= SLOT_C;
    end else if (load) begin
      case (load_idx)
        SLOT_C:  op_c <= sw;
        SLOT_D:  op_d <= sw;
        default: op_n <= sw;
      endcase
      load_idx <= (load_idx == SLOT_N) ? SLOT_C : load_idx + 2'd1;
    end
  end

  // The slot written last is the one just behind the load pointer.
  always_comb begin
    case (load_idx)
      SLOT_C:  last = op_n;
      SLOT_D:  last = op_c;
      default: last = op_d;
    endcase
  end

endmodule

// File: rtl/modexp_ctrl.sv
// Right-to-left square-and-multiply sequencer driving an external mod_mult unit.
// Optional MODEXP_CYCLE_COUNT_EN adds a saturating busy-cycle counter (cyc_cnt).
module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_p,
  input  logic         start_p,
  input  logic         show_p,
  input  logic [W-1:0] sw,
  output logic [W-1:0] led,
  output logic [1:0]   load_idx,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         mm_req,
  output logic [W-1:0] mm_a,
  output logic [W-1:0] mm_b,
  output logic [W-1:0] mm_n,
`ifdef MODEXP_CYCLE_COUNT_EN
  output logic [31:0]  cyc_cnt,
`endif
  input  logic         mm_ack,
  input  logic [W-1:0] mm_p
);

  state_t       state, state_nx;
  logic [W-1:0] op_c, op_d, op_n, last;
  logic [W-1:0] base, exp_r, acc, result, exp_half;
  logic         led_sel, req;
  logic         idle_like, start_ok, load_ok, show_ok, bad, ack_ok;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign start_ok  = start_p && idle_like;
  assign load_ok   = load_p && !start_p && idle_like;
  assign show_ok   = show_p && !start_p && !load_p && (state == ST_DONE);
  assign bad       = (op_n == '0) || (op_c >= op_n);
  assign ack_ok    = req && mm_ack;
  assign exp_half  = exp_r >> 1;

  operand_bank #(.W(W)) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_ok),
    .sw       (sw),
    .op_c     (op_c),
    .op_d     (op_d),
    .op_n     (op_n),
    .last     (last),
    .load_idx (load_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_ok)     state_nx = bad ? ST_ERR : ST_CHECK;
        else if (load_ok) state_nx = ST_IDLE;
      end
      ST_CHECK: begin
        if (exp_r == '0)        state_nx = ST_DONE;
        else if (exp_r[0])      state_nx = ST_MUL;
        else if (exp_half != '0) state_nx = ST_SQR;
        else                    state_nx = ST_DONE;
      end
      ST_MUL: if (ack_ok) state_nx = (exp_half != '0) ? ST_SQR : ST_DONE;
      ST_SQR: if (ack_ok) state_nx = ST_CHECK;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Datapath and registered status flags; flags track the next state so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base    <= '0;
      exp_r   <= '0;
      acc     <= '0;
      result  <= '0;
      led_sel <= 1'b0;
      req     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (start_ok && !bad) begin
        base  <= op_c;
        exp_r <= op_d;
        acc   <= (op_n == W'(1)) ? '0 : W'(1);
      end
      if (state == ST_CHECK && exp_r != '0 && !exp_r[0]) exp_r <= exp_half;
      if (state == ST_MUL && ack_ok) begin
        acc   <= mm_p;
        exp_r <= exp_half;
      end
      if (state == ST_SQR && ack_ok) base <= mm_p;

      // Request is raised one cycle into MUL/SQR and dropped after the ack.
      if (ack_ok)                                   req <= 1'b0;
      else if (state == ST_MUL || state == ST_SQR)  req <= 1'b1;

      if (state_nx == ST_DONE && state != ST_DONE) begin
        result  <= (state == ST_MUL) ? mm_p : acc;
        led_sel <= 1'b1;
      end else if (load_ok) begin
        led_sel <= 1'b0;
      end else if (show_ok) begin
        led_sel <= !led_sel;
      end

      busy <= (state_nx == ST_CHECK) || (state_nx == ST_MUL) || (state_nx == ST_SQR);
      done <= (state_nx == ST_DONE);
      err  <= (state_nx == ST_ERR);
    end
  end

`ifdef MODEXP_CYCLE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       cyc_cnt <= '0;
    else if (start_ok)                cyc_cnt <= '0;
    else if (busy && cyc_cnt != '1)   cyc_cnt <= cyc_cnt + 32'd1;
  end
`endif

  assign mm_req = req;
  assign mm_a   = req ? ((state == ST_MUL) ? acc : base) : '0;
  assign mm_b   = req ? base : '0;
  assign mm_n   = req ? op_n : '0;
  assign led    = led_sel ? result : last;

endmodule
